// File: rtl/hilo_divider.sv
// rtl/hilo_divider.sv - multi-cycle restoring divider with signed/unsigned ops, abort and fixup stage
module hilo_divider #(
  // Quotient bits resolved per clock; legal values are 1, 2 and 4
  parameter int ITERS_PER_CYCLE = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        OP_div,
  input  logic        OP_divu,
  input  logic        Abort,
  input  logic [31:0] Dividend,
  input  logic [31:0] Divisor,
  output logic [31:0] Quotient,
  output logic [31:0] Remainder,
  output logic        Stall,
  output logic        Done
);

  localparam int         L    = 32 / ITERS_PER_CYCLE;
  localparam logic [4:0] LAST = 5'(L - 1);

  typedef enum logic [1:0] {IDLE, BUSY, FIXUP} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q;
  logic [32:0] rem_q;      // partial remainder
  logic [31:0] dvd_q;      // dividend magnitude shifting out, quotient bits shifting in
  logic [31:0] dsr_q;      // divisor magnitude
  logic        neg_quo_q;  // signed op with differing operand signs
  logic        neg_rem_q;  // signed op with negative dividend
  logic        dzero_q;    // divisor was zero at acceptance
  logic [31:0] quotient_q, remainder_q;
  logic        done_q;

  logic        start;
  logic        fix_commit;
  logic [32:0] step_rem;
  logic [31:0] step_dvd;

  assign start      = (state_q == IDLE) && (OP_div || OP_divu);
  assign fix_commit = (state_q == FIXUP) && !Abort;

  assign Quotient  = quotient_q;
  assign Remainder = remainder_q;
  assign Done      = done_q;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort wins over iteration progress, start wins over abort in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = BUSY;
      BUSY:    if (Abort) state_d = IDLE;
               else if (cnt_q == LAST) state_d = FIXUP;
      FIXUP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: stall covers every non-idle cycle
  always_comb begin
    Stall = (state_q != IDLE);
  end

  // ITERS_PER_CYCLE restoring steps, MSB first; a zero divisor naturally yields all-ones
  always_comb begin
    step_rem = rem_q;
    step_dvd = dvd_q;
    for (int i = 0; i < ITERS_PER_CYCLE; i++) begin
      step_rem = {step_rem[31:0], step_dvd[31]};
      step_dvd = {step_dvd[30:0], 1'b0};
      if (step_rem >= {1'b0, dsr_q}) begin
        step_rem    = step_rem - {1'b0, dsr_q};
        step_dvd[0] = 1'b1;
      end
    end
  end

  // Operand capture on acceptance and iteration datapath
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dzero_q   <= 1'b0;
    end else if (start) begin
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= (OP_div && Dividend[31]) ? -Dividend : Dividend;
      dsr_q     <= (OP_div && Divisor[31])  ? -Divisor  : Divisor;
      neg_quo_q <= OP_div && (Dividend[31] ^ Divisor[31]);
      neg_rem_q <= OP_div && Dividend[31];
      dzero_q   <= (Divisor == 32'd0);
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q + 5'd1;
      rem_q <= step_rem;
      dvd_q <= step_dvd;
    end
  end

  // Result registers and done pulse; divide-by-zero keeps the all-ones quotient unsigned-looking
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= fix_commit;
      if (fix_commit) begin
        quotient_q  <= (neg_quo_q && !dzero_q) ? -dvd_q : dvd_q;
        remainder_q <= neg_rem_q ? -rem_q[31:0] : rem_q[31:0];
      end
    end
  end

endmodule

// File: tb/tb_hilo_divider.sv
// tb/tb_hilo_divider.sv - self-checking bench for hilo_divider (L=32 and L=8 instances)
module tb_hilo_divider;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        OP_div = 1'b0, OP_divu = 1'b0, Abort = 1'b0;
  logic [31:0] Dividend = '0, Divisor = '0;
  logic        en4 = 1'b0;
  logic [31:0] q1, r1, q4, r4;
  logic        st1, dn1, st4, dn4;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  hilo_divider #(.ITERS_PER_CYCLE(1)) dut1 (
    .clock(clock), .reset(reset), .OP_div(OP_div), .OP_divu(OP_divu), .Abort(Abort),
    .Dividend(Dividend), .Divisor(Divisor), .Quotient(q1), .Remainder(r1),
    .Stall(st1), .Done(dn1));

  hilo_divider #(.ITERS_PER_CYCLE(4)) dut4 (
    .clock(clock), .reset(reset), .OP_div(OP_div & en4), .OP_divu(OP_divu & en4),
    .Abort(Abort & en4), .Dividend(Dividend), .Divisor(Divisor), .Quotient(q4),
    .Remainder(r4), .Stall(st4), .Done(dn4));

  typedef struct {
    bit          sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eq;
    logic [31:0] er;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain arithmetic, truncating division, remainder takes dividend sign
  function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) begin
      q = 32'hFFFFFFFF;
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
      q = 32'h80000000;
      r = 0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endfunction

  // Start a divide (optionally with Abort asserted the same cycle) and check both result and timing
  task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b, input bit ab,
                         input bit en, input logic [31:0] eq, input logic [31:0] er, input string nm);
    int          scnt[2], dcnt[2];
    bit          fin[2];
    logic        dfirst[2];
    logic [31:0] qf[2], rf[2];
    logic        st[2], dn[2];
    logic [31:0] qq[2], rr[2];
    @(negedge clock);
    OP_div = sgn; OP_divu = !sgn; Dividend = a; Divisor = b; Abort = ab; en4 = en;
    for (int k = 0; k < 2; k++) begin
      scnt[k] = 0; dcnt[k] = 0; fin[k] = 0; dfirst[k] = 0; qf[k] = '0; rf[k] = '0;
    end
    for (int c = 1; c <= 45; c++) begin
      @(negedge clock);
      OP_div = 0; OP_divu = 0; Abort = 0;
      Dividend = $urandom; Divisor = $urandom;
      st[0] = st1; dn[0] = dn1; qq[0] = q1; rr[0] = r1;
      st[1] = st4; dn[1] = dn4; qq[1] = q4; rr[1] = r4;
      for (int k = 0; k < 2; k++) begin
        if (dn[k]) dcnt[k]++;
        if (!fin[k]) begin
          if (st[k]) scnt[k]++;
          else begin
            fin[k] = 1; dfirst[k] = dn[k]; qf[k] = qq[k]; rf[k] = rr[k];
          end
        end
      end
    end
    chk({nm, " L32 stall"}, scnt[0], 33);
    chk({nm, " L32 done"}, {31'd0, dfirst[0]}, 1);
    chk({nm, " L32 pulses"}, dcnt[0], 1);
    chk({nm, " L32 Q"}, qf[0], eq);
    chk({nm, " L32 R"}, rf[0], er);
    if (en) begin
      chk({nm, " L8 stall"}, scnt[1], 9);
      chk({nm, " L8 done"}, {31'd0, dfirst[1]}, 1);
      chk({nm, " L8 pulses"}, dcnt[1], 1);
      chk({nm, " L8 Q"}, qf[1], eq);
      chk({nm, " L8 R"}, rf[1], er);
    end
  endtask

  vec_t vecs[12];

  initial begin
    logic [31:0] a, b, eq, er;
    bit          sgn;
    int          n, dc;

    vecs[0]  = '{0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{1, 32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE};
    vecs[2]  = '{1, 32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2};
    vecs[3]  = '{1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0};
    vecs[4]  = '{0, 32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678};
    vecs[5]  = '{1, 32'hFFFFFF9C,   32'd0,          32'hFFFFFFFF,   32'hFFFFFF9C};
    vecs[6]  = '{0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0};
    vecs[7]  = '{0, 32'd5,          32'd9,          32'd0,          32'd5};
    vecs[8]  = '{1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE};
    vecs[9]  = '{0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000};
    vecs[10] = '{1, 32'h80000000,   32'd1,          32'h80000000,   32'd0};
    vecs[11] = '{1, 32'd7,          32'd0,          32'hFFFFFFFF,   32'd7};

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst Q", q1, 0);
    chk("rst R", r1, 0);
    chk("rst stall", {31'd0, st1}, 0);
    chk("rst done", {31'd0, dn1}, 0);
    chk("rst L8 stall", {31'd0, st4}, 0);
    reset = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++)
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, 0, 1, vecs[i].eq, vecs[i].er, $sformatf("vec%0d", i));

    // Randomized against the reference model
    for (int i = 0; i < 40; i++) begin
      sgn = 1'($urandom);
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'd0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      if (i % 7 == 3) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      ref_div(sgn, a, b, eq, er);
      run_div(sgn, a, b, 0, 1, eq, er, $sformatf("rnd%0d", i));
    end

    // Start while busy is ignored
    @(negedge clock);
    OP_divu = 1; Dividend = 100; Divisor = 7; en4 = 0;
    @(negedge clock);
    OP_divu = 0;
    repeat (4) @(negedge clock);
    OP_divu = 1; Dividend = 9; Divisor = 3;
    @(negedge clock);
    OP_divu = 0;
    n = 0;
    while (st1 && n < 100) begin @(negedge clock); n++; end
    chk("busy timeout", {31'd0, st1}, 0);
    chk("busy done", {31'd0, dn1}, 1);
    chk("busy Q", q1, 14);
    chk("busy R", r1, 2);
    run_div(0, 32'd9, 32'd3, 0, 1, 32'd3, 32'd0, "after busy");

    // Abort mid-divide: no done, results kept
    @(negedge clock);
    OP_divu = 1; Dividend = 100; Divisor = 7; en4 = 0;
    @(negedge clock);
    OP_divu = 0;
    repeat (9) @(negedge clock);
    Abort = 1;
    @(negedge clock);
    Abort = 0;
    chk("abort stall", {31'd0, st1}, 0);
    dc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (dn1) dc++;
    end
    chk("abort done", dc, 0);
    chk("abort Q", q1, 3);
    chk("abort R", r1, 0);
    // Immediate start, with Abort in the same IDLE cycle
    run_div(1, 32'hFFFFFF9C, 32'd7, 1, 1, 32'hFFFFFFF2, 32'hFFFFFFFE, "abort+start");

    // Asynchronous reset mid-divide
    @(negedge clock);
    OP_divu = 1; Dividend = 100; Divisor = 7; en4 = 1;
    @(negedge clock);
    OP_divu = 0;
    repeat (19) @(negedge clock);
    #2 reset = 0;
    #1;
    chk("mid rst Q", q1, 0);
    chk("mid rst R", r1, 0);
    chk("mid rst stall", {31'd0, st1}, 0);
    chk("mid rst L8 Q", q4, 0);
    @(negedge clock);
    reset = 1;
    run_div(0, 32'd100, 32'd7, 0, 1, 32'd14, 32'd2, "post rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
